// File: rtl/hv_wdg_scan_if.sv
// ============================================================================
// hv_wdg_scan_if : register-arbiter read channel used by the watchdog scanner
// Revision 1.0
// ============================================================================
`default_nettype none

interface hv_wdg_scan_if #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8
);
  logic                 o_wdg_scan_rac_rd_req;
  logic [REG_AW-1:0]    o_wdg_scan_rac_addr;
  logic                 i_rac_wdg_scan_ack;
  logic [REG_DW-1:0]    i_rac_wdg_scan_data;
  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc;

  modport master (
    output o_wdg_scan_rac_rd_req,
    output o_wdg_scan_rac_addr,
    input  i_rac_wdg_scan_ack,
    input  i_rac_wdg_scan_data,
    input  i_rac_wdg_scan_crc
  );

  modport slave (
    input  o_wdg_scan_rac_rd_req,
    input  o_wdg_scan_rac_addr,
    output i_rac_wdg_scan_ack,
    output i_rac_wdg_scan_data,
    output i_rac_wdg_scan_crc
  );
endinterface

`default_nettype wire

// File: rtl/hv_wdg_scan.sv
// ============================================================================
// hv_wdg_scan : periodic register scan with CRC-8 check and ack watchdog
// Revision 1.0
// ============================================================================
`default_nettype none

module hv_wdg_scan #(
  parameter int REG_AW          = 7,
  parameter int REG_DW          = 8,
  parameter int REG_CRC_W       = 8,
  parameter int SCAN_START_ADDR = 0,
  parameter int SCAN_END_ADDR   = 31,
  parameter int SCAN_INTV_CYC   = 1000,
  parameter int ACK_TMO_CYC     = 16
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  input  wire logic              i_scan_en,
  input  wire logic              i_err_clr,
  hv_wdg_scan_if.master          rac,
  output logic                   o_scan_busy,
  output logic                   o_scan_done,
  output logic                   o_crc_err,
  output logic                   o_tmo_err,
  output logic [REG_AW-1:0]      o_err_addr,
  output logic [3:0]             o_err_cnt
);

  localparam int TMO_W  = $clog2(ACK_TMO_CYC + 1);
  localparam int INTV_W = $clog2(SCAN_INTV_CYC + 1);

  localparam logic [REG_AW-1:0] C_START_ADDR = REG_AW'(SCAN_START_ADDR);
  localparam logic [REG_AW-1:0] C_END_ADDR   = REG_AW'(SCAN_END_ADDR);
  localparam logic [TMO_W-1:0]  C_TMO_LAST   = TMO_W'(ACK_TMO_CYC - 1);
  localparam logic [INTV_W-1:0] C_INTV_LAST  = INTV_W'(SCAN_INTV_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_INTV = 2'd3
  } state_t;

  state_t              state_q;
  logic                rd_req_q;
  logic [REG_AW-1:0]   addr_q;
  logic                busy_q;
  logic                done_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [INTV_W-1:0]   intv_cnt_q;
  logic                crc_err_q, crc_err_d;
  logic                tmo_err_q, tmo_err_d;
  logic [REG_AW-1:0]   err_addr_q, err_addr_d;
  logic [3:0]          err_cnt_q, err_cnt_d;

  logic                w_in_req;
  logic                w_ack;
  logic                w_crc_bad;
  logic                w_tmo;

  // Serial CRC-8 (poly 0x07, init 0), data consumed MSB first
  function automatic logic [REG_CRC_W-1:0] crc8(input logic [REG_DW-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = REG_DW - 1; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return REG_CRC_W'(c);
  endfunction

  // A disable in the same cycle masks any ack or timeout
  always_comb begin
    w_in_req  = (state_q == S_REQ) && i_scan_en;
    w_ack     = w_in_req && rac.i_rac_wdg_scan_ack;
    w_crc_bad = w_ack && (crc8(rac.i_rac_wdg_scan_data) != rac.i_rac_wdg_scan_crc);
    w_tmo     = w_in_req && !rac.i_rac_wdg_scan_ack && (tmo_cnt_q == C_TMO_LAST);
  end

  // Clear is applied first so a coincident error lands on a clean status
  always_comb begin
    crc_err_d  = crc_err_q;
    tmo_err_d  = tmo_err_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (i_err_clr) begin
      crc_err_d  = 1'b0;
      tmo_err_d  = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = 4'd0;
    end
    if (w_crc_bad || w_tmo) begin
      if (!crc_err_d && !tmo_err_d) err_addr_d = addr_q;
      if (w_crc_bad) crc_err_d = 1'b1;
      if (w_tmo)     tmo_err_d = 1'b1;
      if (err_cnt_d != 4'hF) err_cnt_d = err_cnt_d + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rd_req_q   <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      intv_cnt_q <= '0;
      crc_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= 4'd0;
    end else begin
      done_q     <= 1'b0;
      crc_err_q  <= crc_err_d;
      tmo_err_q  <= tmo_err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
      if (!i_scan_en) begin
        state_q  <= S_IDLE;
        rd_req_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_REQ;
            addr_q    <= C_START_ADDR;
            rd_req_q  <= 1'b1;
            busy_q    <= 1'b1;
            tmo_cnt_q <= '0;
          end
          S_REQ: begin
            if (w_ack || w_tmo) begin
              rd_req_q <= 1'b0;
              if (addr_q == C_END_ADDR) begin
                state_q    <= S_INTV;
                done_q     <= 1'b1;
                intv_cnt_q <= '0;
              end else begin
                state_q <= S_GAP;
                addr_q  <= addr_q + 1'b1;
              end
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
          end
          S_GAP: begin
            state_q   <= S_REQ;
            rd_req_q  <= 1'b1;
            tmo_cnt_q <= '0;
          end
          S_INTV: begin
            if (intv_cnt_q == C_INTV_LAST) begin
              state_q   <= S_REQ;
              addr_q    <= C_START_ADDR;
              rd_req_q  <= 1'b1;
              tmo_cnt_q <= '0;
            end else begin
              intv_cnt_q <= intv_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rac.o_wdg_scan_rac_rd_req = rd_req_q;
  assign rac.o_wdg_scan_rac_addr   = addr_q;
  assign o_scan_busy               = busy_q;
  assign o_scan_done               = done_q;
  assign o_crc_err                 = crc_err_q;
  assign o_tmo_err                 = tmo_err_q;
  assign o_err_addr                = err_addr_q;
  assign o_err_cnt                 = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hv_wdg_scan.sv
// ============================================================================
// tb_hv_wdg_scan : scoreboard bench for hv_wdg_scan with an arbiter responder
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hv_wdg_scan;

  logic       clk;
  logic       rst_n;
  logic       scan_en;
  logic       err_clr;
  logic       busy, done, crc_err, tmo_err;
  logic [6:0] err_addr;
  logic [3:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] data_tab [32];
  logic [7:0] crc_tab  [32];
  int         no_ack_addr = -1;
  int         wcnt = 0;
  logic       req_prev = 1'b0;
  logic       ack_at_neg = 1'b0;
  int         exp_q [$];

  hv_wdg_scan_if #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) rac_if ();

  hv_wdg_scan dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_scan_en   (scan_en),
    .i_err_clr   (err_clr),
    .rac         (rac_if),
    .o_scan_busy (busy),
    .o_scan_done (done),
    .o_crc_err   (crc_err),
    .o_tmo_err   (tmo_err),
    .o_err_addr  (err_addr),
    .o_err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_crc(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // Arbiter model: ack is presented on the second cycle of a held request
  always @(posedge clk) begin
    #1;
    if (rac_if.o_wdg_scan_rac_rd_req && (int'(rac_if.o_wdg_scan_rac_addr) != no_ack_addr)) begin
      wcnt = wcnt + 1;
      rac_if.i_rac_wdg_scan_ack  = (wcnt == 2);
      rac_if.i_rac_wdg_scan_data = data_tab[rac_if.o_wdg_scan_rac_addr[4:0]];
      rac_if.i_rac_wdg_scan_crc  = crc_tab[rac_if.o_wdg_scan_rac_addr[4:0]];
    end else begin
      wcnt = 0;
      rac_if.i_rac_wdg_scan_ack = 1'b0;
    end
  end

  always @(negedge clk) ack_at_neg = rac_if.i_rac_wdg_scan_ack && rac_if.o_wdg_scan_rac_rd_req;

  // Scoreboard: each new request must match the next expected address
  always @(posedge clk) begin
    #1;
    if (ack_at_neg) chk("req_drop_after_ack", rac_if.o_wdg_scan_rac_rd_req, 1'b0);
    if (rac_if.o_wdg_scan_rac_rd_req && !req_prev) begin
      if (exp_q.size() == 0) chk("req_queue_empty", exp_q.size(), 1);
      else                   chk("req_addr", rac_if.o_wdg_scan_rac_addr, exp_q.pop_front());
    end
    req_prev = rac_if.o_wdg_scan_rac_rd_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    for (int a = 0; a < 32; a++) exp_q.push_back(a);
  endtask

  task automatic good_tables();
    for (int a = 0; a < 32; a++) begin
      data_tab[a] = 8'($urandom_range(0, 255));
      crc_tab[a]  = tb_crc(data_tab[a]);
    end
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin step(); n++; end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic wait_req(input int a, input int max);
    int n = 0;
    while (!(rac_if.o_wdg_scan_rac_rd_req && int'(rac_if.o_wdg_scan_rac_addr) == a) && n < max) begin
      step();
      n++;
    end
    chk($sformatf("req_reached_%0d", a), (n < max), 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_req"}, rac_if.o_wdg_scan_rac_rd_req, 0);
    chk({tag, "_addr"},   rac_if.o_wdg_scan_rac_addr, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_crc"},    crc_err, 0);
    chk({tag, "_tmo"},    tmo_err, 0);
    chk({tag, "_eaddr"},  err_addr, 0);
    chk({tag, "_ecnt"},   err_cnt, 0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    scan_en = 1'b0;
    err_clr = 1'b0;
    rac_if.i_rac_wdg_scan_ack  = 1'b0;
    rac_if.i_rac_wdg_scan_data = 8'h00;
    rac_if.i_rac_wdg_scan_crc  = 8'h00;
    for (int a = 0; a < 32; a++) begin data_tab[a] = 8'h01; crc_tab[a] = 8'h07; end

    repeat (3) step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_req_without_en", rac_if.o_wdg_scan_rac_rd_req, 0);

    // Pass 1: clean scan with data 0x01 / crc 0x07
    push_pass();
    scan_en = 1'b1;
    step();
    chk("busy_on", busy, 1'b1);
    wait_done(400);
    chk("p1_crc", crc_err, 0);
    chk("p1_tmo", tmo_err, 0);
    chk("p1_cnt", err_cnt, 0);
    chk("p1_q_empty", exp_q.size(), 0);

    // Pass 2 set up during the interval; addrs 5 and 9 carry bad CRC
    good_tables();
    data_tab[5] = 8'h01; crc_tab[5] = 8'h00;
    data_tab[9] = 8'h01; crc_tab[9] = 8'h00;
    push_pass();
    step();
    chk("done_one_cycle", done, 0);
    n = 1;
    while (!rac_if.o_wdg_scan_rac_rd_req && n < 2000) begin step(); n++; end
    chk("intv_len", n, 1000);
    wait_req(7, 200);
    chk("p2_crc_mid", crc_err, 1);
    chk("p2_eaddr_mid", err_addr, 5);
    chk("p2_cnt_mid", err_cnt, 1);
    wait_done(300);
    chk("p2_crc", crc_err, 1);
    chk("p2_tmo", tmo_err, 0);
    chk("p2_eaddr", err_addr, 5);
    chk("p2_cnt", err_cnt, 2);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_crc", crc_err, 0);
    chk("clr_eaddr", err_addr, 0);
    chk("clr_cnt", err_cnt, 0);

    // Pass 3: no ack at addr 3
    good_tables();
    no_ack_addr = 3;
    push_pass();
    wait_req(3, 1500);
    n = 0;
    while (rac_if.o_wdg_scan_rac_rd_req && n < 40) begin step(); n++; end
    chk("tmo_len", n, 16);
    chk("p3_tmo", tmo_err, 1);
    chk("p3_crc", crc_err, 0);
    chk("p3_eaddr", err_addr, 3);
    chk("p3_cnt", err_cnt, 1);
    wait_req(4, 10);
    no_ack_addr = -1;
    wait_done(300);

    // Pass 4: clear coincident with CRC error at 7, then disable under ack at 12
    good_tables();
    crc_tab[7]  = ~tb_crc(data_tab[7]);
    crc_tab[12] = ~tb_crc(data_tab[12]);
    push_pass();
    wait_req(7, 1500);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clrwin_crc", crc_err, 1);
    chk("clrwin_tmo", tmo_err, 0);
    chk("clrwin_cnt", err_cnt, 1);
    chk("clrwin_eaddr", err_addr, 7);

    wait_req(12, 100);
    step();
    scan_en = 1'b0;
    step();
    chk("dis_rd_req", rac_if.o_wdg_scan_rac_rd_req, 0);
    chk("dis_busy", busy, 0);
    chk("dis_crc", crc_err, 1);
    chk("dis_cnt", err_cnt, 1);
    chk("dis_eaddr", err_addr, 7);
    exp_q.delete();
    repeat (2) step();
    chk("idle_busy", busy, 0);
    crc_tab[7]  = tb_crc(data_tab[7]);
    crc_tab[12] = tb_crc(data_tab[12]);
    exp_q.push_back(0);
    scan_en = 1'b1;
    wait_req(0, 5);

    // Asynchronous reset in the middle of a request
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_q.delete();
    step();
    rst_n = 1'b1;

    // 17 failing addresses must saturate the counter
    for (int a = 0; a < 17; a++) crc_tab[a] = ~tb_crc(data_tab[a]);
    push_pass();
    wait_done(400);
    chk("sat_cnt", err_cnt, 15);
    chk("sat_crc", crc_err, 1);
    chk("sat_eaddr", err_addr, 0);
    chk("sat_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hv_wdg_scan.md
HV_WDG_SCAN -- requirements
Module: hv_wdg_scan

Interface
REQ-001 The block SHALL take these parameters from hv_param.svh: REG_AW, default 7, register address width.
REQ-002 The block SHALL take these parameters from hv_param.svh: REG_DW, default 8, register data width.
REQ-003 The block SHALL take these parameters from hv_param.svh: REG_CRC_W, default 8, register CRC width.
REQ-004 Local parameter SCAN_START_ADDR, default 0: first address scanned.
REQ-005 Local parameter SCAN_END_ADDR, default 31: last address scanned (inclusive); must be >= SCAN_START_ADDR.
REQ-006 Local parameter SCAN_INTV_CYC, default 1000: idle cycles between scan passes (>=1).
REQ-007 Local parameter ACK_TMO_CYC, default 16: maximum cycles a request may wait for ack (>=4).
REQ-008 The block SHALL use one clock and an asynchronous active-low reset: i_clk  in  1  clock; i_rst_n  in  1  async reset, active low.
REQ-009 Port i_scan_en  in  1: scan enable (level).
REQ-010 Port i_err_clr  in  1: single-cycle pulse that clears the error status.
REQ-011 Port o_wdg_scan_rac_rd_req  out  1: read request to the register arbiter.
REQ-012 Port o_wdg_scan_rac_addr  out  REG_AW: address of the read request.
REQ-013 Port i_rac_wdg_scan_ack  in  1: read-data-valid pulse.
REQ-014 Port i_rac_wdg_scan_data  in  REG_DW: read data, valid with ack.
REQ-015 Port i_rac_wdg_scan_crc  in  REG_CRC_W: stored CRC, valid with ack.
REQ-016 Port o_scan_busy  out  1: high in any state other than IDLE.
REQ-017 Port o_scan_done  out  1: one-cycle pulse at the end of each scan pass.
REQ-018 Error status ports SHALL be: o_crc_err  out  1 (sticky CRC mismatch); o_tmo_err  out  1 (sticky ack timeout); o_err_addr  out  REG_AW (first failing address); o_err_cnt  out  4 (saturating error count).

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, GAP and INTV.
REQ-020 IDLE -> REQ when i_scan_en=1; the address SHALL be loaded with SCAN_START_ADDR.
REQ-021 In REQ, o_wdg_scan_rac_rd_req SHALL be 1 and o_wdg_scan_rac_addr SHALL hold the current address, both registered outputs.
REQ-022 The request SHALL be held until ack or timeout; rd_req SHALL be 0 in the cycle after ack is sampled.
REQ-023 On ack in REQ: the CRC check per REQ-025 SHALL be done in that cycle; then, if addr==SCAN_END_ADDR -> INTV with an o_scan_done pulse next cycle, else address+1 and -> GAP.
REQ-024 GAP SHALL last exactly 1 cycle with rd_req=0, then -> REQ.
REQ-025 CRC rule: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over the REG_DW data bits MSB first; a mismatch against i_rac_wdg_scan_crc SHALL be an error.
REQ-026 Timeout: a counter SHALL clear on REQ entry; if ACK_TMO_CYC cycles elapse in REQ without ack, o_tmo_err SHALL set, the address SHALL advance as for ack, and the next state SHALL be GAP or INTV.
REQ-027 An ack outside the REQ state SHALL be ignored.
REQ-028 INTV SHALL count SCAN_INTV_CYC cycles, then -> REQ with address=SCAN_START_ADDR.
REQ-029 i_scan_en=0 in any state SHALL force IDLE next cycle; rd_req SHALL drop the next cycle; an ack in the same cycle SHALL be discarded; error status SHALL be retained.
REQ-030 On any error: the flag (crc or tmo) SHALL set; o_err_addr SHALL capture the address only if both flags were previously 0; o_err_cnt SHALL increment, saturating at 15.
REQ-031 i_err_clr SHALL clear both flags, o_err_addr and o_err_cnt next cycle; if a new error occurs in the same cycle, the error SHALL win (flag=1, cnt=1, addr captured).
REQ-032 Address arithmetic SHALL be REG_AW bits wide with no wrap beyond SCAN_END_ADDR.

Reset
REQ-033 While i_rst_n=0 the FSM SHALL be in IDLE, and all outputs and counters SHALL be 0, including addr=0.
REQ-034 After reset release, the first request SHALL assert no earlier than the cycle after i_scan_en is sampled high.

Verification
REQ-035 Ack 2 cycles after each req, data 0x01, crc 0x07, addresses 0..31 -> 32 requests each separated by 1 GAP cycle, no errors, o_scan_done pulse, then 1000 idle cycles, then restart at address 0.
REQ-036 Addr 5 returns data 0x01, crc 0x00 -> o_crc_err=1, o_err_addr=5, o_err_cnt=1; a later failure at addr 9 -> o_err_addr stays 5, o_err_cnt=2.
REQ-037 No ack at addr 3 -> after 16 cycles o_tmo_err=1, o_err_addr=3, scan resumes at addr 4.
REQ-038 i_err_clr coincident with a CRC error at addr 7 -> o_crc_err=1, o_err_cnt=1, o_err_addr=7.
REQ-039 i_scan_en dropped while rd_req=1 and ack arrives the same cycle -> rd_req=0 next cycle, no error update, state IDLE; re-enabling starts at addr 0.
REQ-040 Reset asserted mid-REQ -> all outputs 0 immediately (asynchronously); 17 errors without clear -> o_err_cnt=15.
